// File: rtl/imem_responder.sv
// imem_responder: accepts instruction fetch requests, reads a synchronous
// instruction memory and returns responses in order through a 2-entry buffer.
// Faulting fetches (misaligned, or beyond the memory) skip the memory read and
// return instr=0 with err=1.
//
// Ports:
//   i_clk, i_rst                    clock, asynchronous active-high reset
//   i_req_valid/o_req_ready         request handshake, i_req_addr byte address
//   i_flush                         drop all in-flight and buffered responses
//   o_rsp_valid/i_rsp_ready         response handshake
//   o_rsp_addr/o_rsp_instr/o_rsp_err head response payload (0 when not valid)
//   o_mem_en/o_mem_addr/i_mem_data  synchronous memory read port (1-cycle data)
//   o_err_cnt                       saturating count of accepted faulting fetches
module imem_responder #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [31:0]       i_req_addr,
    input  logic              i_flush,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       o_rsp_addr,
    output logic [31:0]       o_rsp_instr,
    output logic              o_rsp_err,
    output logic              o_mem_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [31:0]       i_mem_data,
    output logic [7:0]        o_err_cnt
);

    localparam logic [2:0] L_DEPTH = 3'(DEPTH);

    // Buffer state
    logic [1:0]  r_count;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [31:0] r_buf_addr  [DEPTH];
    logic [31:0] r_buf_instr [DEPTH];
    logic        r_buf_err   [DEPTH];

    // Stage register: request whose memory read is in flight
    logic        r_stg_valid;
    logic [31:0] r_stg_addr;
    logic        r_stg_err;

    logic [7:0]  r_err_cnt;

    logic        w_pop;
    logic        w_push;
    logic        w_accept;
    logic        w_fault;
    logic        w_room;
    logic [2:0]  w_occ;
    logic [31:0] w_push_instr;

    assign o_rsp_valid = (r_count != 2'd0);
    assign w_pop       = o_rsp_valid & i_rsp_ready;

    // Space check counts the in-flight read and credits a same-cycle pop.
    assign w_occ       = 3'(r_count) + 3'(r_stg_valid);
    assign w_room      = (w_occ < (L_DEPTH + 3'(w_pop)));
    assign o_req_ready = ~i_rst & ~i_flush & w_room;
    assign w_accept    = i_req_valid & o_req_ready;

    // Fault: misaligned, or any address bit above the memory's byte range set.
    assign w_fault = (i_req_addr[1:0] != 2'b00) | ((i_req_addr >> (ADDR_W + 2)) != 32'd0);

    assign o_mem_en   = w_accept & ~w_fault;
    assign o_mem_addr = o_mem_en ? i_req_addr[ADDR_W+1:2] : '0;

    assign w_push       = r_stg_valid & ~i_flush;
    assign w_push_instr = r_stg_err ? 32'h0000_0000 : i_mem_data;

    assign o_rsp_addr  = o_rsp_valid ? r_buf_addr[r_rd_ptr]  : 32'h0000_0000;
    assign o_rsp_instr = o_rsp_valid ? r_buf_instr[r_rd_ptr] : 32'h0000_0000;
    assign o_rsp_err   = o_rsp_valid ? r_buf_err[r_rd_ptr]   : 1'b0;
    assign o_err_cnt   = r_err_cnt;

    // Control state: occupancy, pointers, stage, fault counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count     <= 2'd0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_stg_valid <= 1'b0;
            r_stg_addr  <= 32'h0000_0000;
            r_stg_err   <= 1'b0;
            r_err_cnt   <= 8'h00;
        end else begin
            if (i_flush) begin
                r_count  <= 2'd0;
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
            end else begin
                r_count <= r_count + 2'(w_push) - 2'(w_pop);
                if (w_push) begin
                    r_wr_ptr <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
            end
            // No accept is possible during flush, so this also clears the stage.
            r_stg_valid <= w_accept;
            if (w_accept) begin
                r_stg_addr <= i_req_addr;
                r_stg_err  <= w_fault;
            end
            if (w_accept & w_fault & (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    // Buffer payload; contents are masked by o_rsp_valid so no reset needed.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_buf_addr[r_wr_ptr]  <= r_stg_addr;
            r_buf_instr[r_wr_ptr] <= w_push_instr;
            r_buf_err[r_wr_ptr]   <= r_stg_err;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Testbench for imem_responder: directed scenarios plus random traffic, all
// checked cycle by cycle against a queue-based behavioural model.
module tb_imem_responder;

    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              i_rst = 1'b0;
    logic              i_req_valid = 1'b0;
    logic              o_req_ready;
    logic [31:0]       i_req_addr = 32'h0;
    logic              i_flush = 1'b0;
    logic              o_rsp_valid;
    logic              i_rsp_ready = 1'b0;
    logic [31:0]       o_rsp_addr;
    logic [31:0]       o_rsp_instr;
    logic              o_rsp_err;
    logic              o_mem_en;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       i_mem_data;
    logic [7:0]        o_err_cnt;

    always #5 clk = ~clk;

    imem_responder #(.ADDR_W(ADDR_W), .DEPTH(2)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_addr  (i_req_addr),
        .i_flush     (i_flush),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_addr  (o_rsp_addr),
        .o_rsp_instr (o_rsp_instr),
        .o_rsp_err   (o_rsp_err),
        .o_mem_en    (o_mem_en),
        .o_mem_addr  (o_mem_addr),
        .i_mem_data  (i_mem_data),
        .o_err_cnt   (o_err_cnt)
    );

    // Synchronous instruction memory environment
    logic [31:0] mem [256];
    logic [31:0] mem_q = 32'h0;
    always @(posedge clk) begin
        if (o_mem_en) mem_q <= mem[o_mem_addr];
    end
    assign i_mem_data = mem_q;

    // Behavioural model: response queue plus one pending memory read
    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } rsp_t;

    rsp_t        m_fifo [$];
    bit          m_pend;
    logic [31:0] m_pend_addr;
    bit          m_pend_err;
    int          m_err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit is_fault(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd4 * 32'd256);
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_pend    = 0;
        m_err_cnt = 0;
    endtask

    // One clock cycle: drive inputs, check every output, advance the model.
    task automatic step(input bit v, input logic [31:0] a, input bit fl, input bit rr);
        int   occ;
        bit   pop;
        bit   ready;
        bit   acc;
        bit   flt;
        rsp_t r;
        @(negedge clk);
        i_req_valid = v;
        i_req_addr  = a;
        i_flush     = fl;
        i_rsp_ready = rr;
        #1;
        occ   = m_fifo.size() + int'(m_pend);
        pop   = (m_fifo.size() > 0) && rr;
        ready = !fl && (occ - int'(pop) < 2);
        acc   = v && ready;
        flt   = is_fault(a);
        chk("req_ready", 32'(o_req_ready), 32'(ready));
        chk("mem_en", 32'(o_mem_en), 32'(acc && !flt));
        chk("mem_addr", 32'(o_mem_addr), (acc && !flt) ? a / 4 : 32'h0);
        chk("rsp_valid", 32'(o_rsp_valid), 32'(m_fifo.size() > 0));
        if (m_fifo.size() > 0) begin
            chk("rsp_addr", o_rsp_addr, m_fifo[0].addr);
            chk("rsp_instr", o_rsp_instr, m_fifo[0].instr);
            chk("rsp_err", 32'(o_rsp_err), 32'(m_fifo[0].err));
        end else begin
            chk("rsp_addr_idle", o_rsp_addr, 32'h0);
            chk("rsp_instr_idle", o_rsp_instr, 32'h0);
            chk("rsp_err_idle", 32'(o_rsp_err), 32'h0);
        end
        chk("err_cnt", 32'(o_err_cnt), 32'(m_err_cnt));
        if (fl) begin
            m_fifo.delete();
            m_pend = 0;
        end else begin
            if (pop) void'(m_fifo.pop_front());
            if (m_pend) begin
                r.addr  = m_pend_addr;
                r.err   = m_pend_err;
                r.instr = m_pend_err ? 32'h0 : mem[m_pend_addr[ADDR_W+1:2]];
                m_fifo.push_back(r);
            end
            m_pend      = acc;
            m_pend_addr = a;
            m_pend_err  = flt;
        end
        if (acc && flt && m_err_cnt < 255) m_err_cnt++;
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        @(negedge clk);
        i_req_valid = 0;
        i_flush     = 0;
        i_rsp_ready = 0;
        #2;
        i_rst = 1;
        #1;
        chk("rst_req_ready", 32'(o_req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(o_rsp_valid), 32'h0);
        chk("rst_rsp_addr", o_rsp_addr, 32'h0);
        chk("rst_rsp_instr", o_rsp_instr, 32'h0);
        chk("rst_rsp_err", 32'(o_rsp_err), 32'h0);
        chk("rst_mem_en", 32'(o_mem_en), 32'h0);
        chk("rst_mem_addr", 32'(o_mem_addr), 32'h0);
        chk("rst_err_cnt", 32'(o_err_cnt), 32'h0);
        model_reset();
        @(negedge clk);
        i_rst = 0;
    endtask

    task automatic idle(input int n, input bit rr);
        for (int k = 0; k < n; k++) step(0, 32'h0, 0, rr);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 7))
            0:       a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
            1:       a = $urandom() | 32'h0000_0400;
            default: a = 32'($urandom_range(0, 255)) << 2;
        endcase
        return a;
    endfunction

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = $urandom();
        mem[1] = 32'h2008_0005;
        mem[4] = 32'hCAFE_0004;
        model_reset();
        do_reset();

        // Single fetch
        step(1, 32'h4, 0, 1);
        chk("single_mem_en", 32'(o_mem_en), 32'h1);
        chk("single_mem_addr", 32'(o_mem_addr), 32'h1);
        idle(1, 1);
        idle(1, 1);
        chk("single_valid", 32'(o_rsp_valid), 32'h1);
        chk("single_addr", o_rsp_addr, 32'h4);
        chk("single_instr", o_rsp_instr, 32'h2008_0005);
        idle(2, 1);

        // Back-to-back stream
        for (int k = 0; k < 4; k++) begin
            step(1, 32'(k * 4), 0, 1);
            chk("stream_ready", 32'(o_req_ready), 32'h1);
        end
        idle(3, 1);

        // Backpressure: third request waits for the first pop
        step(1, 32'h0, 0, 0);
        step(1, 32'h4, 0, 0);
        step(1, 32'h8, 0, 0);
        chk("bp_ready_low", 32'(o_req_ready), 32'h0);
        step(1, 32'h8, 0, 0);
        chk("bp_head_stable", o_rsp_addr, 32'h0);
        step(1, 32'h8, 0, 1);
        chk("bp_accept_on_pop", 32'(o_req_ready), 32'h1);
        idle(4, 1);

        // Faulting fetches
        step(1, 32'h6, 0, 1);
        chk("fault_mis_mem_en", 32'(o_mem_en), 32'h0);
        step(1, 32'h400, 0, 1);
        chk("fault_oor_mem_en", 32'(o_mem_en), 32'h0);
        idle(3, 1);
        chk("fault_err_cnt", 32'(o_err_cnt), 32'h2);

        // Flush with one buffered and one in flight
        step(1, 32'h0, 0, 0);
        step(1, 32'h8, 0, 0);
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 0, 1);
        chk("flush_valid_low", 32'(o_rsp_valid), 32'h0);
        step(1, 32'h10, 0, 1);
        idle(1, 1);
        step(0, 32'h0, 0, 1);
        chk("flush_new_instr", o_rsp_instr, 32'hCAFE_0004);
        chk("flush_new_addr", o_rsp_addr, 32'h10);
        idle(2, 1);

        // Random traffic with a mid-stream reset
        for (int k = 0; k < 2000; k++) begin
            step(1'($urandom_range(0, 3) != 0), rand_addr(),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0));
            if (k == 1000) begin
                do_reset();
                step(0, 32'h0, 0, 0);
                chk("post_reset_ready", 32'(o_req_ready), 32'h1);
            end
        end
        idle(4, 1);

        // Fault counter saturation, unaffected by flush
        for (int k = 0; k < 300; k++) step(1, 32'h1, 0, 1);
        idle(3, 1);
        chk("err_cnt_sat", 32'(o_err_cnt), 32'hFF);
        step(0, 32'h0, 1, 1);
        idle(1, 1);
        chk("err_cnt_after_flush", 32'(o_err_cnt), 32'hFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
